// File: rtl/pedestrian_phase_scheduler.sv
// pedestrian_phase_scheduler
//   Grants one pedestrian crossing at a time, round-robin, between vehicle
//   green intervals. Requests are latched into 'pending' at any time. After
//   MIN_GREEN green cycles, and while start=1, a pending request makes the
//   block ask the traffic controller to stop vehicles (hold_req). Once
//   veh_red confirms, one crossing walks for WALK_TIME cycles. A clearance
//   of CLEAR_TIME cycles follows, and then green resumes. Losing veh_red
//   during WALK/CLEAR aborts the phase and sets a sticky violation flag.
//
// Ports
//   clk         rising-edge clock
//   rst         synchronous reset, active low
//   start       enable; 0 only blocks GREEN->HOLD
//   pedestrian  [3:0] per-crossing request (level or pulse)
//   veh_red     vehicle light is red (from traffic controller)
//   hold_req    request to stop vehicle traffic
//   walk        [3:0] one-hot walk grant
//   served_id   [1:0] most recently granted crossing
//   pending     [3:0] latched, not-yet-served requests
//   violation   sticky: veh_red dropped during WALK or CLEAR
module pedestrian_phase_scheduler #(
    parameter int MIN_GREEN  = 8,
    parameter int WALK_TIME  = 6,
    parameter int CLEAR_TIME = 3
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [3:0] pedestrian,
    input  logic       veh_red,
    output logic       hold_req,
    output logic [3:0] walk,
    output logic [1:0] served_id,
    output logic [3:0] pending,
    output logic       violation
);

    localparam int         NUM_XING   = 4;
    localparam logic [7:0] GREEN_MAX  = 8'(MIN_GREEN);
    localparam logic [7:0] WALK_LAST  = 8'(WALK_TIME - 1);
    localparam logic [7:0] CLEAR_LAST = 8'(CLEAR_TIME - 1);

    typedef enum logic [1:0] {GREEN, HOLD, WALK, CLEAR} state_t;

    state_t     state, state_nx;
    logic [7:0] green_cnt, green_cnt_nx;
    logic [7:0] timer, timer_nx;
    logic [3:0] pending_nx, walk_nx;
    logic [1:0] served_nx;
    logic       hold_nx, viol_nx;

    // Round-robin pick: first pending bit at or after served_id+1, wrapping.
    logic [1:0] winner, idx;
    logic       found;

    always_comb begin
        winner = served_id;
        idx    = '0;
        found  = 1'b0;
        for (int k = 1; k <= NUM_XING; k++) begin
            idx = served_id + 2'(k);
            if (!found && pending[idx]) begin
                winner = idx;
                found  = 1'b1;
            end
        end
    end

    // Next-state and next-output logic; every output is a register loaded
    // from these values.
    always_comb begin
        state_nx     = state;
        green_cnt_nx = green_cnt;
        timer_nx     = timer;
        pending_nx   = pending | pedestrian;
        walk_nx      = walk;
        served_nx    = served_id;
        hold_nx      = hold_req;
        viol_nx      = violation;

        case (state)
            GREEN: begin
                hold_nx = 1'b0;
                walk_nx = '0;
                if (green_cnt == GREEN_MAX && start && pending != '0) begin
                    state_nx = HOLD;
                    hold_nx  = 1'b1;
                end else if (green_cnt != GREEN_MAX) begin
                    green_cnt_nx = green_cnt + 8'd1;
                end
            end
            HOLD: begin
                hold_nx = 1'b1;
                walk_nx = '0;
                if (veh_red) begin
                    state_nx  = WALK;
                    served_nx = winner;
                    walk_nx   = 4'b0001 << winner;
                    // A new request for the winner on this same edge survives.
                    pending_nx = (pending & ~(4'b0001 << winner)) | pedestrian;
                    timer_nx  = '0;
                end
            end
            WALK, CLEAR: begin
                if (!veh_red) begin
                    // Vehicles released under a walk: abort straight to green.
                    viol_nx      = 1'b1;
                    state_nx     = GREEN;
                    walk_nx      = '0;
                    hold_nx      = 1'b0;
                    green_cnt_nx = '0;
                end else if (state == WALK) begin
                    if (timer == WALK_LAST) begin
                        state_nx = CLEAR;
                        walk_nx  = '0;
                        timer_nx = '0;
                    end else begin
                        timer_nx = timer + 8'd1;
                    end
                end else begin
                    if (timer == CLEAR_LAST) begin
                        state_nx     = GREEN;
                        hold_nx      = 1'b0;
                        green_cnt_nx = '0;
                    end else begin
                        timer_nx = timer + 8'd1;
                    end
                end
            end
            default: begin
                state_nx     = GREEN;
                walk_nx      = '0;
                hold_nx      = 1'b0;
                green_cnt_nx = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state     <= GREEN;
            green_cnt <= '0;
            timer     <= '0;
            pending   <= '0;
            walk      <= '0;
            served_id <= 2'd3;
            hold_req  <= 1'b0;
            violation <= 1'b0;
        end else begin
            state     <= state_nx;
            green_cnt <= green_cnt_nx;
            timer     <= timer_nx;
            pending   <= pending_nx;
            walk      <= walk_nx;
            served_id <= served_nx;
            hold_req  <= hold_nx;
            violation <= viol_nx;
        end
    end

endmodule

// File: doc/pedestrian_phase_scheduler.md
PEDESTRIAN_PHASE_SCHEDULER -- requirements
Module: pedestrian_phase_scheduler

Interface
REQ-001 SHALL provide parameter: MIN_GREEN, 8, minimum vehicle-green cycles before a pedestrian phase (legal 1..255).
REQ-002 SHALL provide parameter: WALK_TIME, 6, cycles one walk grant stays asserted (legal 1..255).
REQ-003 SHALL provide parameter: CLEAR_TIME, 3, all-walk-off clearance cycles after a walk (legal 1..255).
REQ-004 SHALL have port: clk  input  1  single clock; all logic on its rising edge.
REQ-005 SHALL have port: rst  input  1  reset, synchronous, active-low.
REQ-006 SHALL have port: start  input  1  enable; 0 blocks leaving GREEN, requests still latched.
REQ-007 SHALL have port: pedestrian  input  4  per-crossing request, bit i = crossing i, level or pulse.
REQ-008 SHALL have port: veh_red  input  1  traffic light controller status: vehicle light is red.
REQ-009 SHALL have port: hold_req  output  1  request to traffic light controller to stop vehicle traffic.
REQ-010 SHALL have port: walk  output  4  one-hot walk grant, bit i = crossing i.
REQ-011 SHALL have port: served_id  output  2  index of the most recently granted crossing.
REQ-012 SHALL have port: pending  output  4  latched, not-yet-served requests.
REQ-013 SHALL have port: violation  output  1  sticky: veh_red dropped during WALK or CLEAR.

Function
REQ-014 SHALL latch requests: pending[i] set on any cycle with pedestrian[i]=1, in any state.
REQ-015 SHALL implement FSM states GREEN, HOLD, WALK, CLEAR; all outputs registered.
REQ-016 SHALL in GREEN: green_cnt cleared on entry, +1 per cycle, saturating at MIN_GREEN; hold_req=0, walk=0.
REQ-017 SHALL go GREEN->HOLD when green_cnt==MIN_GREEN, start=1, pending!=0.
REQ-018 SHALL in HOLD assert hold_req=1 and wait indefinitely for veh_red=1, then go to WALK.
REQ-019 SHALL select the winner on the HOLD->WALK edge, round-robin: search starts at served_id+1 mod 4, wraps, first pending bit wins.
REQ-020 SHALL on WALK entry: served_id=winner, pending[winner] cleared, walk=one-hot(winner).
REQ-021 SHALL set pending[winner] again if pedestrian[winner]=1 on that same cycle (set dominates clear).
REQ-022 SHALL hold walk for exactly WALK_TIME cycles, then enter CLEAR with walk=0 for exactly CLEAR_TIME cycles.
REQ-023 SHALL keep hold_req=1 through HOLD, WALK and CLEAR; CLEAR->GREEN drops hold_req on the following cycle.
REQ-024 SHALL serve one crossing per pedestrian phase; other pending crossings wait for a full new GREEN of MIN_GREEN cycles.
REQ-025 SHALL on veh_red=0 in WALK or CLEAR: set violation, force walk=0 next cycle, go to GREEN; served request stays cleared.
REQ-026 SHALL keep violation set until reset; scheduling continues normally afterwards.
REQ-027 SHALL never assert more than one walk bit, nor any walk bit while hold_req=0 or outside WALK.
REQ-028 SHALL let start=0 during HOLD/WALK/CLEAR complete the current phase; it only blocks GREEN->HOLD.

Reset
REQ-029 SHALL with rst=0 at a clock edge: state=GREEN, green_cnt=0, pending=0, walk=0, hold_req=0, violation=0, served_id=3, so crossing 0 has top priority.
REQ-030 SHALL with reset mid-phase drop walk and hold_req on the next edge and discard all pending requests.

Verification
REQ-031 SHALL cover: reset, start=1, pedestrian=0001 pulse at cycle 2, veh_red tied 1 -> hold_req rises after cycle 8, walk=0001 for 6 cycles, 3 cycles walk=0, hold_req falls, served_id=0.
REQ-032 SHALL cover: pedestrian=1111 one cycle, veh_red=1 -> successive phases grant walk 0001, 0010, 0100, 1000, each separated by 8 GREEN cycles; pending ends 0000.
REQ-033 SHALL cover: served_id=2, pending=1011 -> next grant walk=1000 (id 3), then id 0, then id 1.
REQ-034 SHALL cover: veh_red held 0 in HOLD for 50 cycles -> hold_req stays 1, walk stays 0000; veh_red=1 -> walk asserts next cycle.
REQ-035 SHALL cover: veh_red drops at 3rd WALK cycle -> violation=1 next cycle, walk=0000, state GREEN; violation stays 1 until rst=0.
REQ-036 SHALL cover: start=0 with pending=0100 for 40 cycles -> no hold_req; start=1 -> hold_req asserts next cycle; rst=0 mid-WALK -> all outputs at reset values next edge.
